// File: rtl/alu_sequencer.sv
// Multi-cycle control stage around the Hmmm ALU: latches operands, holds the ALU enabled
// until mul/div/mod settle, captures result/flags and traps div/mod by zero.
// Optional saturation of add/sub overflow on capture is enabled by defining ALU_SAT_EN.
module alu_sequencer #(
  parameter int unsigned MULDIV_WAIT = 32'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op_in,
  input  logic [15:0] opnd_a,
  input  logic [15:0] opnd_b,
  output logic [15:0] tmp1,
  output logic [15:0] tmp2,
  output logic [2:0]  alu_op,
  output logic        alu_en,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_sign,
  output logic [15:0] result_q,
  output logic        zero_q,
  output logic        carry_q,
  output logic        sign_q,
  output logic        div_zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [3:0] LAST_CNT = 4'(MULDIV_WAIT - 32'd1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        trap_s;
  logic        op_is_muldiv_s;
  logic        exec_last_s;
  logic [15:0] cap_result_d;
  logic        cap_zero_d;
  logic        cap_carry_d;
  logic        cap_sign_d;

  // Trap detection on the incoming request and end-of-EXEC detection on the latched opcode
  always_comb begin
    trap_s         = ((op_in == OP_DIV) || (op_in == OP_MOD)) && (opnd_b == 16'h0000);
    op_is_muldiv_s = (alu_op == OP_MUL) || (alu_op == OP_DIV) || (alu_op == OP_MOD);
    if (op_is_muldiv_s) begin
      exec_last_s = (cnt_q == LAST_CNT);
    end else begin
      exec_last_s = 1'b1;
    end
  end

  // Values written into the capture registers on the final EXEC edge
  always_comb begin
`ifdef ALU_SAT_EN
    // Overflow direction follows operand A: a positive A can only overflow upwards.
    if (((alu_op == OP_ADD) || (alu_op == OP_SUB)) && alu_carry) begin
      cap_result_d = tmp1[15] ? 16'h8000 : 16'h7FFF;
      cap_zero_d   = 1'b0;
      cap_carry_d  = 1'b1;
      cap_sign_d   = tmp1[15];
    end else begin
      cap_result_d = alu_result;
      cap_zero_d   = alu_zero;
      cap_carry_d  = alu_carry;
      cap_sign_d   = alu_sign;
    end
`else
    cap_result_d = alu_result;
    cap_zero_d   = alu_zero;
    cap_carry_d  = alu_carry;
    cap_sign_d   = alu_sign;
`endif
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      tmp1     <= 16'h0000;
      tmp2     <= 16'h0000;
      alu_op   <= 3'b000;
      alu_en   <= 1'b0;
      result_q <= 16'h0000;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tmp1   <= opnd_a;
            tmp2   <= opnd_b;
            alu_op <= op_in;
            busy   <= 1'b1;
            if (trap_s) begin
              result_q <= 16'h0000;
              zero_q   <= 1'b1;
              carry_q  <= 1'b0;
              sign_q   <= 1'b0;
              div_zero <= 1'b1;
              done     <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              div_zero <= 1'b0;
              cnt_q    <= 4'd0;
              alu_en   <= 1'b1;
              state_q  <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (exec_last_s) begin
            result_q <= cap_result_d;
            zero_q   <= cap_zero_d;
            carry_q  <= cap_carry_d;
            sign_q   <= cap_sign_d;
            alu_en   <= 1'b0;
            done     <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          alu_en  <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control stage directly upstream and downstream of the Hmmm ALU.
- Accepts an arithmetic request from the decode/register-file side.
- Latches the operands into the ALU's tmp1/tmp2 inputs, drives op and enable, and waits long enough for mul/div/mod to settle.
- Captures result and zero/carry/sign flags into registers and signals completion with a one-cycle done pulse.
- Traps divide/modulo by zero before the ALU is enabled.

Parameters:
MULDIV_WAIT, 2, number of EXEC cycles for op 010/011/100 (legal range 1..15); all other ops use 1 EXEC cycle.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
op_in  input  3  ALU opcode (000 add, 001 sub, 010 mul, 011 div, 100 mod, others pass to ALU)
opnd_a  input  16  first operand (signed)
opnd_b  input  16  second operand (signed)
tmp1  output  16  registered operand A to ALU
tmp2  output  16  registered operand B to ALU
alu_op  output  3  registered opcode to ALU
alu_en  output  1  ALU output enable; high only in EXEC
alu_result  input  16  ALU result
alu_zero  input  1  ALU zero flag
alu_carry  input  1  ALU overflow/carry flag
alu_sign  input  1  ALU sign flag
result_q  output  16  captured result
zero_q  output  1  captured zero flag
carry_q  output  1  captured carry flag
sign_q  output  1  captured sign flag
div_zero  output  1  set when the last request was div/mod with opnd_b == 0
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset values (rst_n low at an edge): state=IDLE, and all outputs 0.
  - This covers tmp1, tmp2, alu_op, alu_en, result_q, zero_q, carry_q, sign_q, div_zero, busy and done.
  - Reset mid-operation aborts the request: no done pulse, captured registers cleared.
- States:
  - IDLE: busy=0, alu_en=0.
  - EXEC: alu_en=1, cycle counter running.
  - DONE: done=1 for exactly one cycle.
- IDLE -> EXEC: on an edge with start=1. That edge loads tmp1<=opnd_a, tmp2<=opnd_b, alu_op<=op_in, clears div_zero and sets counter=0.
- IDLE -> DONE (divide-by-zero trap): on an edge with start=1, op_in in {011,100} and opnd_b==0.
  - Loads tmp1/tmp2/alu_op as normal.
  - result_q<=0, zero_q<=1, carry_q<=0, sign_q<=0, div_zero<=1.
  - ALU is never enabled.
- EXEC: counter increments each edge. The final EXEC edge captures result_q<=alu_result plus the three flags, then goes to DONE.
  - Final edge for op 010/011/100 is when counter == MULDIV_WAIT-1.
  - Final edge for all other ops is the first edge.
- DONE -> IDLE unconditionally on the next edge.
- Latency, with start sampled at edge 0:
  - add/sub/other: capture at edge 1, done high between edges 1 and 2.
  - mul/div/mod: capture at edge MULDIV_WAIT, done the following cycle.
  - div-zero trap: done high between edges 0 and 1.
- start while busy (EXEC or DONE) is ignored, not queued. The inputs are don't-care outside IDLE.
- tmp1/tmp2/alu_op hold until the next accepted request.
- result_q, flags and div_zero hold until overwritten by the next completion or trap.
- alu_result is sampled only during EXEC; while alu_en is low the ALU output is high-Z and must never be captured.
- Back-to-back: start may be asserted in the cycle done is high, but it is only accepted at the edge after DONE (first IDLE cycle).

Optional Feature:
Macro ALU_SAT_EN.
- Defined: on a capture for op 000 or 001 with alu_carry=1, the captured values are replaced by a saturated result.
  - result_q <= 16'h7FFF if tmp1[15]==0, else 16'h8000.
  - carry_q <= 1.
  - zero_q <= 0.
  - sign_q <= saturated result bit 15.
- Not defined: result_q and flags are captured unmodified from the ALU.

Test Plan:
- Reset then add: rst_n low 2 cycles, start with op 000, a=5, b=7 -> every output 0 during reset; done 2 cycles after start, result_q=12, zero_q=0, carry_q=0, sign_q=0, busy high for 2 cycles.
- Multiply with MULDIV_WAIT=2: op 010, a=-3, b=4 -> alu_en high exactly 2 cycles, done on cycle 3, result_q=16'hFFF4, sign_q=1.
- Divide by zero: op 011, a=100, b=0 -> alu_en never high, done 1 cycle after start, result_q=0, zero_q=1, div_zero=1. A following op 100 with a=7, b=3 -> div_zero cleared at accept, result_q=1.
- Add overflow: op 000, a=16'h7FFF, b=1 -> carry_q=1. Without ALU_SAT_EN, result_q=16'h8000 and sign_q=1. With ALU_SAT_EN, result_q=16'h7FFF and sign_q=0.
- Start while busy: start op 001 a=10 b=3, then pulse start again in EXEC with a=1 b=1 -> second request ignored, result_q=7, exactly one done pulse.
- Reset mid-op: op 011 a=20 b=4, rst_n low during EXEC -> no done pulse, all outputs 0, next request a=20 b=4 completes with result_q=5.
